// File: rtl/cfs_apb_slave_regs.sv
// cfs_apb_slave_regs
//   APB slave register bank with programmable wait states and error responses.
//   Register map (word aligned byte addresses):
//     0x00 CTRL     RW  [3:0] wait-state count, upper bits read 0
//     0x04 STATUS   RO  [15:0] completed transfers, [31:16] errored transfers
//     0x08 SCRATCH0 RW
//     0x0C SCRATCH1 RW
//     0x10 ID       RO  ID_VALUE
// Ports:
//   pclk, preset_n          clock, synchronous active-low reset
//   psel, penable, paddr,
//   pwrite, pwdata          APB master request
//   pready, prdata, pslverr APB completion response (decoded from registered state)
module cfs_apb_slave_regs #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter logic [3:0]  DEFAULT_WAIT = 4'd0,
  parameter logic [31:0] ID_VALUE     = 32'hA5B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH0 = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH1 = ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_ID       = ADDR_WIDTH'(32'h10);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [31:0]           scratch0_q, scratch0_d;
  logic [31:0]           scratch1_q, scratch1_d;
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic        hit;
  logic        err;
  logic [31:0] rd_val;

  // Decode of the captured address; misaligned addresses never match a map entry.
  always_comb begin
    hit    = 1'b1;
    rd_val = '0;
    case (addr_q)
      A_CTRL:     rd_val = {28'd0, ctrl_q};
      A_STATUS:   rd_val = {err_cnt_q, xfer_cnt_q};
      A_SCRATCH0: rd_val = scratch0_q;
      A_SCRATCH1: rd_val = scratch1_q;
      A_ID:       rd_val = ID_VALUE;
      default:    hit    = 1'b0;
    endcase
    err = !hit || (write_q && ((addr_q == A_STATUS) || (addr_q == A_ID)));
  end

  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign pslverr = pready && err;
  assign prdata  = (pready && !write_q && !err) ? rd_val : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;

    // A setup phase is accepted in IDLE and, as abort plus restart, in ACCESS.
    if (psel && !penable) begin
      state_d = ACCESS;
      cnt_d   = ctrl_q;
      addr_d  = paddr;
      write_d = pwrite;
      wdata_d = pwdata;
    end else if (state_q == ACCESS) begin
      if (!psel) begin
        state_d = IDLE;
      end else if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = IDLE;
        if (xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
        if (err) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else if (write_q) begin
          case (addr_q)
            A_CTRL:     ctrl_d     = wdata_q[3:0];
            A_SCRATCH0: scratch0_d = wdata_q;
            A_SCRATCH1: scratch1_d = wdata_q;
            default:    ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      ctrl_q     <= DEFAULT_WAIT;
      scratch0_q <= '0;
      scratch1_q <= '0;
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
